bidir_port_ctrl: RTL and testbench
==================================

BIDIR_PORT_CTRL -- requirements
Module: bidir_port_ctrl

Interface
REQ-001 SHALL have parameter DW, default 8: width of pad, a, b, sum and capture data.
REQ-002 SHALL have parameter CW, default 8: width of the period counter.
REQ-003 SHALL have parameter TA_CYC, default 2: turnaround cycles, legal range 1..15.
REQ-004 SHALL have port clk  input  1  clock, all state updates on the rising edge.
REQ-005 SHALL have port resetn  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port dir_req  input  1  requested direction: 1 = drive pad, 0 = sample pad.
REQ-007 SHALL have port a  input  DW  first addend.
REQ-008 SHALL have port b  input  DW  second addend.
REQ-009 SHALL have port period  input  CW  capture interval; capture occurs when count equals period.
REQ-010 SHALL have port pad  inout  DW  bidirectional bus.
REQ-011 SHALL have port pad_oe  output  1  registered drive enable.
REQ-012 SHALL have port cap_data  output  DW  last captured pad value.
REQ-013 SHALL have port cap_valid  output  1  one-cycle pulse marking a new cap_data.
REQ-014 SHALL have port busy  output  1  high in IDLE and TA states.

Function
REQ-015 SHALL implement the FSM states IDLE, TA, RX and TX.
REQ-016 SHALL remain in IDLE for exactly one cycle after reset release, then enter TA.
REQ-017 SHALL stay in TA for exactly TA_CYC cycles, then enter TX if dir_req=1, else RX; dir_req is sampled on the last TA cycle.
REQ-018 SHALL move from RX to TA when dir_req=1, and from TX to TA when dir_req=0.
REQ-019 SHALL set pad_oe=1 only while in TX; pad SHALL be high-Z in every other state.
REQ-020 SHALL drive pad = sum when pad_oe=1.
REQ-021 SHALL register sum <= a+b every cycle in all non-reset states, truncated to DW bits (wraps modulo 2^DW).
REQ-022 SHALL clear the counter on RX entry and increment it each RX cycle, wrapping to 0 after reaching period (period+1 cycles per interval).
REQ-023 SHALL, in RX when count==period, register cap_data <= pad and pulse cap_valid high for one cycle.
REQ-024 SHALL, with period=0, capture on every RX cycle.
REQ-025 SHALL still capture if the capture point coincides with dir_req rising; the state leaves RX on the next edge.
REQ-026 SHALL NOT capture or increment the counter outside RX; cap_data holds its value.
REQ-027 SHALL ignore dir_req toggles during TA; only the last-cycle sample applies.
REQ-028 SHALL, on a period change mid-interval, take effect at the next comparison; if count > new period, the counter wraps through 2^CW.

Reset
REQ-029 SHALL, while resetn=0, force state=IDLE, pad_oe=0, pad high-Z, sum=0, count=0, cap_data=0, cap_valid=0, busy=1, TA counter=0.
REQ-030 SHALL, on reset assertion in TX, release pad immediately without waiting for a clock.

Configuration
REQ-031 SHALL support macro BIDIR_PORT_SAT_EN.
REQ-032 SHALL, when BIDIR_PORT_SAT_EN is defined, compute sum as an unsigned saturating add, clamped to 2^DW-1 on overflow.
REQ-033 SHALL, when BIDIR_PORT_SAT_EN is undefined, compute sum with modulo wrap per REQ-021.

Verification
REQ-034 SHALL verify: release reset with dir_req=0 -> busy=1 for 1+TA_CYC cycles, then RX with pad_oe=0.
REQ-035 SHALL verify: RX, period=3, external pad=8'h5A -> cap_valid pulses every 4 cycles with cap_data=8'h5A.
REQ-036 SHALL verify: dir_req 0->1 in RX, a=8'h10, b=8'h22 -> exactly TA_CYC cycles of high-Z, then pad=8'h32 with pad_oe=1.
REQ-037 SHALL verify: a=8'hF0, b=8'h20 in TX -> pad=8'h10, or 8'hFF with BIDIR_PORT_SAT_EN.
REQ-038 SHALL verify: resetn low mid-TX -> pad high-Z and all outputs zero in the same cycle, with no clock edge.
REQ-039 SHALL verify: period=0 in RX -> cap_valid high every cycle; capture coincident with dir_req rising still updates cap_data.

Source files
------------

// File: rtl/bidir_port_ctrl.sv
// bidir_port_ctrl: direction-sequenced bidirectional pad controller.
// It drives a registered a+b sum onto the pad in TX. In RX it samples the
// pad at a programmable interval. Every direction change passes through a
// fixed turnaround period (TA) with the pad released.
// Build option: define BIDIR_PORT_SAT_EN to make the sum saturate at
// 2^DW-1. Without it, the sum wraps modulo 2^DW.
//
// state | meaning
// IDLE  | one cycle after reset release, pad released
// TA    | turnaround, TA_CYC cycles, pad released
// RX    | pad sampled every period+1 cycles
// TX    | pad driven with registered sum
module bidir_port_ctrl #(
  parameter int DW     = 8,
  parameter int CW     = 8,
  parameter int TA_CYC = 2
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          dir_req,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic [CW-1:0] period,
  inout  wire  [DW-1:0] pad,
  output logic          pad_oe,
  output logic [DW-1:0] cap_data,
  output logic          cap_valid,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, TA, RX, TX} state_t;

  localparam logic [3:0] TA_LAST = 4'(TA_CYC - 1);

  state_t        state_q, state_d;
  logic [3:0]    ta_cnt_q, ta_cnt_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] sum_q, sum_d;
  logic [DW-1:0] cap_data_q, cap_data_d;
  logic          cap_valid_q, cap_valid_d;
  logic          pad_oe_q, pad_oe_d;

`ifdef BIDIR_PORT_SAT_EN
  logic [DW:0] sum_full;
  assign sum_full = {1'b0, a} + {1'b0, b};
  assign sum_d    = sum_full[DW] ? {DW{1'b1}} : sum_full[DW-1:0];
`else
  assign sum_d = a + b;
`endif

  // Next-state, turnaround timer, capture counter and capture data.
  always_comb begin
    state_d     = state_q;
    ta_cnt_d    = 4'd0;
    cnt_d       = '0;
    cap_data_d  = cap_data_q;
    cap_valid_d = 1'b0;
    case (state_q)
      IDLE: state_d = TA;
      TA: begin
        if (ta_cnt_q == TA_LAST) begin
          state_d = dir_req ? TX : RX;
        end else begin
          ta_cnt_d = ta_cnt_q + 4'd1;
        end
      end
      RX: begin
        // The capture still happens on the cycle that dir_req rises.
        if (cnt_q == period) begin
          cap_data_d  = pad;
          cap_valid_d = 1'b1;
          cnt_d       = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
        if (dir_req) state_d = TA;
      end
      TX: begin
        if (!dir_req) state_d = TA;
      end
      default: state_d = IDLE;
    endcase
    // The pad enable is registered from the next state, so it matches TX exactly.
    pad_oe_d = (state_d == TX);
  end

  // State and datapath registers; reset releases the pad without a clock edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      ta_cnt_q    <= 4'd0;
      cnt_q       <= '0;
      sum_q       <= '0;
      cap_data_q  <= '0;
      cap_valid_q <= 1'b0;
      pad_oe_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      ta_cnt_q    <= ta_cnt_d;
      cnt_q       <= cnt_d;
      sum_q       <= sum_d;
      cap_data_q  <= cap_data_d;
      cap_valid_q <= cap_valid_d;
      pad_oe_q    <= pad_oe_d;
    end
  end

  assign pad       = pad_oe_q ? sum_q : {DW{1'bz}};
  assign pad_oe    = pad_oe_q;
  assign cap_data  = cap_data_q;
  assign cap_valid = cap_valid_q;
  assign busy      = (state_q == IDLE) || (state_q == TA);

endmodule

// File: tb/tb_bidir_port_ctrl.sv
// Directed bench for bidir_port_ctrl (DW=8, CW=8, TA_CYC=2).
module tb_bidir_port_ctrl;

  logic       clk = 1'b0;
  logic       resetn;
  logic       dir_req;
  logic [7:0] a, b, period;
  wire  [7:0] pad;
  logic       pad_oe, cap_valid, busy;
  logic [7:0] cap_data;
  logic [7:0] drv;
  logic       drv_en;
  logic [7:0] exp_sum;

  int n_vec = 0;
  int n_err = 0;

  assign pad = drv_en ? drv : 8'hzz;

  bidir_port_ctrl #(.DW(8), .CW(8), .TA_CYC(2)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .dir_req   (dir_req),
    .a         (a),
    .b         (b),
    .period    (period),
    .pad       (pad),
    .pad_oe    (pad_oe),
    .cap_data  (cap_data),
    .cap_valid (cap_valid),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    resetn  = 1'b0;
    dir_req = 1'b0;
    a       = 8'h00;
    b       = 8'h00;
    period  = 8'd3;
    drv     = 8'h5A;
    drv_en  = 1'b1;

    #1;
    chk("rst_cap_data", 32'(cap_data), 32'h00);
    chk("rst_cap_valid", 32'(cap_valid), 32'h0);
    chk("rst_pad_oe", 32'(pad_oe), 32'h0);
    chk("rst_busy", 32'(busy), 32'h1);

    // Release reset: busy for 1 + TA_CYC cycles, then RX.
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      chk($sformatf("boot_busy_%0d", k), 32'(busy), 32'(k < 3));
    end
    chk("rx_pad_oe", 32'(pad_oe), 32'h0);

    // RX with period=3: a capture every 4 cycles.
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      chk($sformatf("p3_valid_%0d", i), 32'(cap_valid), 32'((i % 4) == 0));
      if ((i % 4) == 0) chk($sformatf("p3_data_%0d", i), 32'(cap_data), 32'h5A);
    end

    // Switch to TX. A dir_req glitch during TA is ignored.
    a       = 8'h10;
    b       = 8'h22;
    drv_en  = 1'b0;
    dir_req = 1'b1;
    @(negedge clk);
    chk("ta1_pad_oe", 32'(pad_oe), 32'h0);
    chk("ta1_busy", 32'(busy), 32'h1);
    dir_req = 1'b0;
    @(negedge clk);
    chk("ta2_pad_oe", 32'(pad_oe), 32'h0);
    dir_req = 1'b1;
    @(negedge clk);
    chk("tx_pad_oe", 32'(pad_oe), 32'h1);
    chk("tx_pad", 32'(pad), 32'h32);
    chk("tx_busy", 32'(busy), 32'h0);

    // Overflowing addition.
    a = 8'hF0;
    b = 8'h20;
`ifdef BIDIR_PORT_SAT_EN
    exp_sum = 8'hFF;
`else
    exp_sum = 8'h10;
`endif
    @(negedge clk);
    chk("tx_ovf_pad", 32'(pad), 32'(exp_sum));

    // Asynchronous reset mid-TX, between clock edges.
    #2;
    resetn = 1'b0;
    #1;
    chk("arst_pad_oe", 32'(pad_oe), 32'h0);
    chk("arst_cap_data", 32'(cap_data), 32'h00);
    chk("arst_cap_valid", 32'(cap_valid), 32'h0);
    chk("arst_busy", 32'(busy), 32'h1);

    // period=0: a capture on every RX cycle.
    period  = 8'd0;
    dir_req = 1'b0;
    drv     = 8'h11;
    drv_en  = 1'b1;
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("p0_rx_busy", 32'(busy), 32'h0);
    chk("p0_first_valid", 32'(cap_valid), 32'h0);
    drv = 8'h21;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      chk($sformatf("p0_valid_%0d", i), 32'(cap_valid), 32'h1);
      chk($sformatf("p0_data_%0d", i), 32'(cap_data), 32'(8'h20 + i));
      drv = 8'(8'h21 + i);
    end

    // Capture on the same cycle as dir_req rising.
    drv     = 8'hC3;
    dir_req = 1'b1;
    @(negedge clk);
    chk("coin_valid", 32'(cap_valid), 32'h1);
    chk("coin_data", 32'(cap_data), 32'hC3);
    chk("coin_busy", 32'(busy), 32'h1);
    drv_en = 1'b0;
    @(negedge clk);
    chk("ta_no_valid", 32'(cap_valid), 32'h0);
    chk("ta_hold_data", 32'(cap_data), 32'hC3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
